// File: rtl/ni_flit_depacketizer_if.sv
// Flit link bundle between the NoC receive port, the depacketizer and the NI core.
// The err_count signal exists only when NI_RX_ERR_CNT_EN is defined.
interface ni_flit_depacketizer_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CNT_WIDTH  = 4,
  parameter int FTYPEWD    = 3
);
  logic [FLIT_WIDTH-1:0] in_flit;
  logic [FTYPEWD-1:0]    in_type;
  logic                  in_valid;
  logic                  in_ready;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  out_first;
  logic                  out_last;
  logic [CNT_WIDTH-1:0]  out_index;
  logic                  out_valid;
  logic                  out_ready;
  logic                  seq_err;
  logic                  len_err;
`ifdef NI_RX_ERR_CNT_EN
  logic [7:0]            err_count;

  modport slave (
    input  in_flit, in_type, in_valid, out_ready,
    output in_ready, out_flit, out_first, out_last,
    output out_index, out_valid, seq_err, len_err,
    output err_count
  );

  modport master (
    output in_flit, in_type, in_valid, out_ready,
    input  in_ready, out_flit, out_first, out_last,
    input  out_index, out_valid, seq_err, len_err,
    input  err_count
  );
`else
  modport slave (
    input  in_flit, in_type, in_valid, out_ready,
    output in_ready, out_flit, out_first, out_last,
    output out_index, out_valid, seq_err, len_err
  );

  modport master (
    output in_flit, in_type, in_valid, out_ready,
    input  in_ready, out_flit, out_first, out_last,
    input  out_index, out_valid, seq_err, len_err
  );
`endif
endinterface

// File: rtl/ni_flit_depacketizer.sv
// Receive-side flit sequencer: checks HEAD/PAYL/TAIL/SING grammar, tags flits.
// Optional saturating error counter enabled by defining NI_RX_ERR_CNT_EN.
module ni_flit_depacketizer #(
  parameter int FLIT_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
) (
  input logic clock,
  input logic reset,
  ni_flit_depacketizer_if.slave bus
);
  localparam int FTYPEWD = 3;
  localparam logic [FTYPEWD-1:0] ENC_HEAD = 3'd1;
  localparam logic [FTYPEWD-1:0] ENC_PAYL = 3'd2;
  localparam logic [FTYPEWD-1:0] ENC_TAIL = 3'd3;
  localparam logic [FTYPEWD-1:0] ENC_SING = 3'd4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BODY = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [CNT_WIDTH-1:0]  step;
  logic                  sat;
  logic                  in_rdy;
  logic                  acc;
  logic                  fwd;
  logic                  seq;
  logic                  len;
  logic                  first_nxt;
  logic                  last_nxt;
  logic                  is_head;
  logic                  is_payl;
  logic                  is_tail;
  logic                  is_sing;
  logic                  in_body;

  logic [FLIT_WIDTH-1:0] o_flit;
  logic                  o_first;
  logic                  o_last;
  logic [CNT_WIDTH-1:0]  o_index;
  logic                  o_valid;
  logic                  o_seq;
  logic                  o_len;

  assign in_rdy  = !reset && (!o_valid || bus.out_ready);
  assign acc     = bus.in_valid && in_rdy;
  assign is_head = (bus.in_type == ENC_HEAD);
  assign is_payl = (bus.in_type == ENC_PAYL);
  assign is_tail = (bus.in_type == ENC_TAIL);
  assign is_sing = (bus.in_type == ENC_SING);
  assign in_body = (state == BODY);
  assign sat     = (cnt == CNT_MAX);
  assign step    = sat ? cnt : cnt + 1'b1;

  assign bus.in_ready  = in_rdy;
  assign bus.out_flit  = o_flit;
  assign bus.out_first = o_first;
  assign bus.out_last  = o_last;
  assign bus.out_index = o_index;
  assign bus.out_valid = o_valid;
  assign bus.seq_err   = o_seq;
  assign bus.len_err   = o_len;

  // Grammar check and next index for the flit on the input
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fwd       = 1'b0;
    seq       = 1'b0;
    len       = 1'b0;
    first_nxt = 1'b0;
    last_nxt  = 1'b0;
    unique case (1'b1)
      is_head: begin
        fwd       = 1'b1;
        first_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = BODY;
        seq       = in_body;
      end
      is_sing: begin
        fwd       = 1'b1;
        first_nxt = 1'b1;
        last_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
        seq       = in_body;
      end
      is_payl: begin
        if (in_body) begin
          fwd     = 1'b1;
          cnt_nxt = step;
          len     = sat;
        end else begin
          seq = 1'b1;
        end
      end
      is_tail: begin
        if (in_body) begin
          fwd       = 1'b1;
          cnt_nxt   = step;
          len       = sat;
          last_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          seq = 1'b1;
        end
      end
      default: seq = 1'b1;
    endcase
  end

  // Packet state advances only on accepted flits
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (acc) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One-deep output stage; a dropped flit only lets a pop drain it
  always_ff @(posedge clock) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_flit  <= '0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      o_index <= '0;
    end else if (acc && fwd) begin
      o_valid <= 1'b1;
      o_flit  <= bus.in_flit;
      o_first <= first_nxt;
      o_last  <= last_nxt;
      o_index <= cnt_nxt;
    end else if (o_valid && bus.out_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Error pulses for the flit accepted at this edge
  always_ff @(posedge clock) begin
    if (reset) begin
      o_seq <= 1'b0;
      o_len <= 1'b0;
    end else begin
      o_seq <= acc && seq;
      o_len <= acc && len;
    end
  end

`ifdef NI_RX_ERR_CNT_EN
  logic [7:0] err_cnt;

  assign bus.err_count = err_cnt;

  // Count error cycles, saturating at 255
  always_ff @(posedge clock) begin
    if (reset) begin
      err_cnt <= '0;
    end else if ((o_seq || o_len) && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
